// File: rtl/branch_redirect_ctrl.sv
// Front-end recovery after EX branch resolution: one PC redirect per mispredict,
// then an IF/ID flush window. Also flags misaligned taken targets and counts mispredicts.
module branch_redirect_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ex_valid,
  input  logic              i_branch_taken,
  input  logic              i_pred_taken,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_target,
  output logic              o_redir_valid,
  input  logic              i_redir_ready,
  output logic [ADDR_W-1:0] o_redir_pc,
  output logic              o_flush,
  output logic              o_busy,
  output logic              o_misalign,
  output logic [CNT_W-1:0]  o_mispredict_cnt
);

  // state    | meaning
  // IDLE     | watching EX for mispredicts / misaligned targets
  // REDIRECT | redirect offered to fetch, waiting for ready
  // FLUSH    | redirect accepted, flushing IF/ID for FLUSH_CYCLES cycles
  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t            state, state_nx;
  logic [2:0]        fcnt, fcnt_nx;
  logic              valid_nx, flush_nx, busy_nx, misalign_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic [CNT_W-1:0]  cnt_nx;
  logic              bad, mp;
  logic [ADDR_W-1:0] new_pc;

  assign bad    = i_ex_valid & i_branch_taken & (i_target[1:0] != 2'b00);
  assign mp     = i_ex_valid & (i_branch_taken != i_pred_taken) & ~bad;
  assign new_pc = i_branch_taken ? i_target : i_pc + ADDR_W'(4);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      fcnt             <= '0;
      o_redir_valid    <= 1'b0;
      o_redir_pc       <= '0;
      o_flush          <= 1'b0;
      o_busy           <= 1'b0;
      o_misalign       <= 1'b0;
      o_mispredict_cnt <= '0;
    end else begin
      state            <= state_nx;
      fcnt             <= fcnt_nx;
      o_redir_valid    <= valid_nx;
      o_redir_pc       <= pc_nx;
      o_flush          <= flush_nx;
      o_busy           <= busy_nx;
      o_misalign       <= misalign_nx;
      o_mispredict_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    fcnt_nx     = fcnt;
    valid_nx    = o_redir_valid;
    pc_nx       = o_redir_pc;
    flush_nx    = o_flush;
    busy_nx     = o_busy;
    misalign_nx = 1'b0;
    cnt_nx      = o_mispredict_cnt;
    unique case (state)
      IDLE: begin
        valid_nx = 1'b0;
        flush_nx = 1'b0;
        busy_nx  = 1'b0;
        if (bad) begin
          misalign_nx = 1'b1;
        end else if (mp) begin
          pc_nx    = new_pc;
          valid_nx = 1'b1;
          flush_nx = 1'b1;
          busy_nx  = 1'b1;
          state_nx = REDIRECT;
          if (o_mispredict_cnt != '1) cnt_nx = o_mispredict_cnt + CNT_W'(1);
        end
      end
      REDIRECT: begin
        if (i_redir_ready) begin
          valid_nx = 1'b0;
          fcnt_nx  = FLUSH_LOAD;
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        // fcnt==0 marks the last flush cycle
        if (fcnt == 3'd0) begin
          flush_nx = 1'b0;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          fcnt_nx = fcnt - 3'd1;
        end
      end
      default: begin
        valid_nx = 1'b0;
        flush_nx = 1'b0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: vector table plus hand-written multi-cycle
// sequences. A second instance with a 3-bit counter covers saturation.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, taken, pred, ready;
  logic [31:0] pc, target;

  logic        redir_valid, flush, busy, misalign;
  logic [31:0] redir_pc;
  logic [31:0] cnt;
  logic        s_valid, s_flush, s_busy, s_misalign;
  logic [31:0] s_pc;
  logic [2:0]  s_cnt;

  int checks = 0;
  int failures = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .i_branch_taken(taken),
    .i_pred_taken(pred), .i_pc(pc), .i_target(target),
    .o_redir_valid(redir_valid), .i_redir_ready(ready), .o_redir_pc(redir_pc),
    .o_flush(flush), .o_busy(busy), .o_misalign(misalign), .o_mispredict_cnt(cnt)
  );

  branch_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(3)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .i_branch_taken(taken),
    .i_pred_taken(pred), .i_pc(pc), .i_target(target),
    .o_redir_valid(s_valid), .i_redir_ready(ready), .o_redir_pc(s_pc),
    .o_flush(s_flush), .o_busy(s_busy), .o_misalign(s_misalign), .o_mispredict_cnt(s_cnt)
  );

  typedef struct {
    logic        ex_valid, taken, pred;
    logic [31:0] pc, target;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_misalign;
  } vec_t;

  vec_t vecs[30];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic t, input logic p,
                       input logic [31:0] a, input logic [31:0] tg);
    ex_valid = v; taken = t; pred = p; pc = a; target = tg;
  endtask

  task automatic drain;
    int n = 0;
    ex_valid = 1'b0;
    ready = 1'b1;
    while (busy && n < 20) begin
      tick;
      n++;
    end
    chk("drain_timeout", 64'(busy), 64'd0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ready = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, 64'(redir_valid), 64'd0);
    chk({name, "_pc"}, 64'(redir_pc), 64'd0);
    chk({name, "_flush"}, 64'(flush), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_misalign"}, 64'(misalign), 64'd0);
    chk({name, "_cnt"}, 64'(cnt), 64'd0);
    chk({name, "_sat_cnt"}, 64'(s_cnt), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1, 1, 1, 32'h40, 32'h80, 0, 32'h0, 0};
    vecs[1] = '{1, 0, 0, 32'h44, 32'h90, 0, 32'h0, 0};
    vecs[2] = '{0, 1, 0, 32'h48, 32'hA0, 0, 32'h0, 0};
    vecs[3] = '{1, 1, 0, 32'h80, 32'h100, 1, 32'h100, 0};
    vecs[4] = '{1, 0, 1, 32'h200, 32'h1234, 1, 32'h204, 0};
    vecs[5] = '{1, 0, 1, 32'hFFFF_FFFC, 32'h0, 1, 32'h0, 0};
    vecs[6] = '{1, 1, 0, 32'h300, 32'h102, 0, 32'h0, 1};
    vecs[7] = '{1, 1, 1, 32'h300, 32'h103, 0, 32'h0, 1};
    vecs[8] = '{1, 0, 1, 32'h400, 32'h401, 1, 32'h404, 0};
    vecs[9] = '{1, 1, 0, 32'h10, 32'h20, 1, 32'h20, 0};
    for (int i = 10; i < 30; i++)
      vecs[i] = '{1, i[0], i[0], 32'(i * 8), 32'(i * 16), 0, 32'h0, 0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ready = 1'b0;
    tick;
    tick;
    chk_all_zero("reset");
    rst = 1'b0;

    // table: one input cycle, check registered response, then let the FSM settle
    exp_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      ready = 1'b1;
      drive(vecs[i].ex_valid, vecs[i].taken, vecs[i].pred, vecs[i].pc, vecs[i].target);
      tick;
      if (vecs[i].exp_valid) exp_cnt++;
      chk($sformatf("vec%0d_valid", i), 64'(redir_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_flush", i), 64'(flush), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_misalign", i), 64'(misalign), 64'(vecs[i].exp_misalign));
      chk($sformatf("vec%0d_cnt", i), 64'(cnt), 64'(exp_cnt));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_pc", i), 64'(redir_pc), 64'(vecs[i].exp_pc));
      drain;
    end

    // taken mispredict with ready tied high; wrong-path mispredicts during flush
    do_reset;
    ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h100);
    tick;
    chk("t2_n1_valid", 64'(redir_valid), 64'd1);
    chk("t2_n1_pc", 64'(redir_pc), 64'h100);
    chk("t2_n1_flush", 64'(flush), 64'd1);
    chk("t2_n1_busy", 64'(busy), 64'd1);
    chk("t2_n1_cnt", 64'(cnt), 64'd1);
    drive(1'b1, 1'b0, 1'b1, 32'h500, 32'h0);
    tick;
    chk("t2_n2_valid", 64'(redir_valid), 64'd0);
    chk("t2_n2_flush", 64'(flush), 64'd1);
    tick;
    chk("t2_n3_flush", 64'(flush), 64'd1);
    chk("t2_n3_busy", 64'(busy), 64'd1);
    ex_valid = 1'b0;
    tick;
    chk("t2_n4_flush", 64'(flush), 64'd0);
    chk("t2_n4_busy", 64'(busy), 64'd0);
    chk("t2_n4_valid", 64'(redir_valid), 64'd0);
    chk("t2_n4_cnt", 64'(cnt), 64'd1);
    drive(1'b1, 1'b0, 1'b1, 32'h600, 32'h0);
    tick;
    chk("t2_first_idle_valid", 64'(redir_valid), 64'd1);
    chk("t2_first_idle_pc", 64'(redir_pc), 64'h604);
    chk("t2_first_idle_cnt", 64'(cnt), 64'd2);
    drain;

    // backpressure: outputs hold while ready is low, EX ignored
    do_reset;
    ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
    tick;
    chk("t4_valid", 64'(redir_valid), 64'd1);
    chk("t4_pc", 64'(redir_pc), 64'h204);
    drive(1'b1, 1'b1, 1'b0, 32'h700, 32'h900);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk($sformatf("t4_hold%0d_valid", k), 64'(redir_valid), 64'd1);
      chk($sformatf("t4_hold%0d_pc", k), 64'(redir_pc), 64'h204);
      chk($sformatf("t4_hold%0d_flush", k), 64'(flush), 64'd1);
    end
    ex_valid = 1'b0;
    ready = 1'b1;
    tick;
    chk("t4_hs_valid", 64'(redir_valid), 64'd0);
    chk("t4_hs_flush", 64'(flush), 64'd1);
    drain;
    chk("t4_cnt", 64'(cnt), 64'd1);

    // misalign is a single pulse with no redirect
    do_reset;
    ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h102);
    tick;
    chk("t5_misalign", 64'(misalign), 64'd1);
    chk("t5_valid", 64'(redir_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    ex_valid = 1'b0;
    tick;
    chk("t5_misalign_end", 64'(misalign), 64'd0);
    chk("t5_cnt", 64'(cnt), 64'd0);

    // reset while a redirect is pending, even with ready and a new mispredict present
    ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h100);
    tick;
    chk("t5_redir_valid", 64'(redir_valid), 64'd1);
    rst = 1'b1;
    ready = 1'b1;
    tick;
    chk_all_zero("t5_rst");
    rst = 1'b0;
    ex_valid = 1'b0;

    // saturation on the 3-bit instance
    do_reset;
    for (int k = 0; k < 9; k++) begin
      ready = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 32'(k * 16), 32'h0);
      tick;
      drain;
    end
    chk("t6_sat_cnt", 64'(s_cnt), 64'd7);
    chk("t6_wide_cnt", 64'(cnt), 64'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
